// File: rtl/interrupt_controller_pkg.sv
// Types and constants shared between the interrupt controller and the CSR block.
package ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } ic_state_e;

    localparam logic [31:0] CAUSE_BASE_DEF = 32'h8000_0010;

    // CSR addresses used on the CSR<->IC interface
    localparam logic [11:0] CSR_MIE    = 12'h304;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

endpackage

// File: rtl/interrupt_controller_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at last+1 and wraps modulo N.
module rr_arbiter
    import ic_pkg::*;
#(
    parameter int N  = 6,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_valid
);

    // Walk from the farthest slot toward the nearest so the nearest requester wins.
    always_comb begin
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            automatic int idx = (int'(i_last) + k) % N;
            if (i_req[idx]) begin
                o_gnt_idx   = IW'(idx);
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises irq lines, latches rising edges as pending,
// arbitrates enabled sources round-robin and issues one trap at a time.
module interrupt_controller
    import ic_pkg::*;
#(
    parameter int          N_IRQ       = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] CAUSE_BASE  = CAUSE_BASE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [N_IRQ-1:0] i_mie,
    input  logic             i_irq_en,
    input  logic             i_mret,
    output logic             o_int,
    output logic [31:0]      o_mcause,
    output logic             o_int_active,
    output logic [N_IRQ-1:0] o_pending
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_cand;
    logic [N_IRQ-1:0] w_clr;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_gnt_valid;
    logic             w_claim;

    ic_state_e        r_state;
    logic [IW-1:0]    r_last;
    logic [31:0]      r_mcause;
    logic [N_IRQ-1:0] r_pending;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_hist;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync <= '0;
                r_hist <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq[g]};
                r_hist <= r_sync[SYNC_STAGES-1];
            end
        end

        assign w_edge[g] = r_sync[SYNC_STAGES-1] & ~r_hist;
    end

    assign w_cand = r_pending & i_mie & {N_IRQ{i_irq_en}};

    rr_arbiter #(
        .N  (N_IRQ),
        .IW (IW)
    ) u_arb (
        .i_req       (w_cand),
        .i_last      (r_last),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    assign w_claim = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_clr   = w_claim ? (N_IRQ'(1) << w_gnt_idx) : '0;

    // A new edge on the source being claimed is a fresh event, so set beats clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= IW'(N_IRQ - 1);
            r_mcause  <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            case (r_state)
                ST_IDLE: begin
                    if (w_claim) begin
                        r_state  <= ST_TAKE;
                        r_last   <= w_gnt_idx;
                        r_mcause <= CAUSE_BASE + 32'(w_gnt_idx);
                    end
                end
                ST_TAKE:    r_state <= ST_SERVICE;
                ST_SERVICE: if (i_mret) r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_int        = (r_state == ST_TAKE);
    assign o_int_active = (r_state == ST_SERVICE);
    assign o_mcause     = r_mcause;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: latency, round-robin, masking, busy window, reset.
module tb_interrupt_controller;

    logic        clk;
    logic        rst_n;
    logic [5:0]  irq;
    logic [5:0]  mie;
    logic        irq_en;
    logic        mret;
    logic        int_o;
    logic [31:0] mcause;
    logic        int_active;
    logic [5:0]  pending;

    int n_chk  = 0;
    int n_fail = 0;

    interrupt_controller #(
        .N_IRQ       (6),
        .SYNC_STAGES (2),
        .CAUSE_BASE  (32'h8000_0010)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq        (irq),
        .i_mie        (mie),
        .i_irq_en     (irq_en),
        .i_mret       (mret),
        .o_int        (int_o),
        .o_mcause     (mcause),
        .o_int_active (int_active),
        .o_pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for an int pulse, then check the reported cause.
    task automatic wait_int(input string tag, input logic [31:0] exp_cause);
        int n = 0;
        while (!int_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_int"}, 32'(int_o), 32'd1);
        chk({tag, "_cause"}, mcause, exp_cause);
    endtask

    task automatic do_mret();
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic watch_no_int(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen |= int_o;
        end
    endtask

    logic seen;

    initial begin
        rst_n = 1'b0; irq = '0; mie = '0; irq_en = 1'b0; mret = 1'b0;
        #1;
        chk("rst_int", 32'(int_o), 0);
        chk("rst_active", 32'(int_active), 0);
        chk("rst_mcause", mcause, 0);
        chk("rst_pending", 32'(pending), 0);
        ticks(2);
        rst_n = 1'b1;
        tick();

        // single source: pending after 3 edges of sync, int one cycle later
        mie = 6'b000100; irq_en = 1'b1; irq = 6'b000100;
        ticks(3);
        chk("single_pend", 32'(pending), 32'h04);
        chk("single_noint_yet", 32'(int_o), 0);
        tick();
        chk("single_int", 32'(int_o), 1);
        chk("single_cause", mcause, 32'h8000_0012);
        chk("single_pend_clr", 32'(pending), 0);
        tick();
        chk("single_int_1cyc", 32'(int_o), 0);
        chk("single_active", 32'(int_active), 1);
        ticks(2);
        chk("single_active_hold", 32'(int_active), 1);
        mret = 1'b1; tick(); mret = 1'b0;
        chk("single_mret_idle", 32'(int_active), 0);
        chk("single_cause_kept", mcause, 32'h8000_0012);

        // round-robin from reset: claim order 0,3,5 then wrap to 0 before 3
        irq = '0; rst_n = 1'b0; ticks(2); rst_n = 1'b1; tick();
        mie = 6'h3F; irq = 6'b101001;
        wait_int("rr_a0", 32'h8000_0010);
        chk("rr_pend_a", 32'(pending), 32'h28);
        do_mret();
        wait_int("rr_a3", 32'h8000_0013);
        chk("rr_pend_b", 32'(pending), 32'h20);
        do_mret();
        wait_int("rr_a5", 32'h8000_0015);
        do_mret();
        irq = '0; ticks(4);
        irq = 6'b001001;
        wait_int("rr_wrap0", 32'h8000_0010);
        do_mret();
        wait_int("rr_wrap3", 32'h8000_0013);
        do_mret();

        // busy window: edge on 4 during service of 0, second int 2 cycles after mret
        irq = '0; ticks(4);
        irq = 6'b000001;
        wait_int("busy_first", 32'h8000_0010);
        irq = 6'b010001;
        watch_no_int(6, seen);
        chk("busy_noint", 32'(seen), 0);
        chk("busy_pend4", 32'(pending), 32'h10);
        chk("busy_active", 32'(int_active), 1);
        mret = 1'b1; tick(); mret = 1'b0;
        chk("busy_gap_int", 32'(int_o), 0);
        chk("busy_gap_idle", 32'(int_active), 0);
        tick();
        chk("busy_second_int", 32'(int_o), 1);
        chk("busy_second_cause", mcause, 32'h8000_0014);
        do_mret();

        // masking: pending held while disabled, taken one cycle after mie rises
        irq = '0; ticks(4);
        mie = 6'b111101; irq = 6'b000010;
        watch_no_int(5, seen);
        chk("mask_noint", 32'(seen), 0);
        chk("mask_pend", 32'(pending), 32'h02);
        mie = 6'h3F;
        tick();
        chk("mask_int", 32'(int_o), 1);
        chk("mask_cause", mcause, 32'h8000_0011);
        do_mret();

        // global disable holds off the trap
        irq = '0; ticks(4);
        irq_en = 1'b0; irq = 6'b000100;
        watch_no_int(6, seen);
        chk("gen_noint", 32'(seen), 0);
        chk("gen_pend", 32'(pending), 32'h04);
        irq_en = 1'b1;
        tick();
        chk("gen_int", 32'(int_o), 1);
        chk("gen_cause", mcause, 32'h8000_0012);
        do_mret();

        // mret while idle has no effect
        mret = 1'b1; tick(); mret = 1'b0;
        chk("idle_mret_active", 32'(int_active), 0);
        chk("idle_mret_int", 32'(int_o), 0);
        chk("idle_mret_cause", mcause, 32'h8000_0012);
        tick();
        chk("idle_mret_int2", 32'(int_o), 0);

        // edge on the claimed source in the claim cycle re-arms pending
        irq = '0; ticks(4);
        mie = 6'b111101; irq = 6'b000010;
        ticks(3);
        chk("cc_pend_first", 32'(pending), 32'h02);
        irq = '0; ticks(3);
        irq = 6'b000010;
        ticks(2);
        mie = 6'h3F;
        tick();
        chk("cc_int", 32'(int_o), 1);
        chk("cc_cause", mcause, 32'h8000_0011);
        chk("cc_pend_kept", 32'(pending), 32'h02);
        do_mret();
        wait_int("cc_again", 32'h8000_0011);
        chk("cc_pend_clr", 32'(pending), 0);
        do_mret();

        // asynchronous reset during service
        irq = '0; ticks(4);
        irq = 6'b001000;
        wait_int("rs_take", 32'h8000_0013);
        tick();
        irq = 6'b011000;
        ticks(3);
        chk("rs_pend_pre", 32'(pending), 32'h10);
        chk("rs_active_pre", 32'(int_active), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_active", 32'(int_active), 0);
        chk("rs_pending", 32'(pending), 0);
        chk("rs_mcause", mcause, 0);
        chk("rs_int", 32'(int_o), 0);
        irq = '0;
        ticks(2);
        rst_n = 1'b1;
        tick();
        irq = 6'b100001;
        wait_int("rs_prio0", 32'h8000_0010);
        do_mret();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
